uart_rx_unit: RTL and testbench

Serial receive front end for the single-cycle CPU's `uart_rx` pin. It synchronises the asynchronous line and decodes 8N1 frames, LSB first, at a fixed bit period. Each good byte is held in a one-entry register with a valid/ack handshake, so the CPU's UART peripheral register can read it. Framing errors and overruns are reported as flags.

---
 rtl/uart_rx_unit.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_unit.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_unit
// Brief  : 8N1 UART receiver with input synchroniser, one-entry holding
//          register (valid/ack), framing-error pulse and sticky overrun flag.
// Rev    : 1.0
// ============================================================================
module uart_rx_unit #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       frame_err,
   output logic       overrun
);

   localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
   localparam int c_half  = CLKS_PER_BIT / 2;
   localparam logic [c_cnt_w-1:0] c_start_last = c_cnt_w'(c_half - 1);
   localparam logic [c_cnt_w-1:0] c_bit_last   = c_cnt_w'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   logic               r_sync1;
   logic               r_sync2;
   logic               r_rx_s;
   state_t             r_state;
   state_t             w_state_n;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_n;
   logic [2:0]         r_idx;
   logic [2:0]         w_idx_n;
   logic [7:0]         r_sh;
   logic [7:0]         w_sh_n;
   logic [7:0]         r_data;
   logic [7:0]         w_data_n;
   logic               r_valid;
   logic               w_valid_n;
   logic               r_ferr;
   logic               w_ferr_n;
   logic               r_ovr;
   logic               w_ovr_n;

   // Two metastability flops, then rx_s as the single registered sample point.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= uart_rx;
         r_sync2 <= r_sync1;
         r_rx_s  <= r_sync2;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= 3'd0;
         r_sh    <= 8'h00;
         r_data  <= 8'h00;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_idx   <= w_idx_n;
         r_sh    <= w_sh_n;
         r_data  <= w_data_n;
         r_valid <= w_valid_n;
         r_ferr  <= w_ferr_n;
         r_ovr   <= w_ovr_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_idx_n   = r_idx;
      w_sh_n    = r_sh;
      w_data_n  = r_data;
      w_valid_n = r_valid;
      w_ferr_n  = 1'b0;
      w_ovr_n   = r_ovr;

      // An ack frees the holding register; a coinciding good frame reloads it below.
      if (rx_ack && r_valid) begin
         w_valid_n = 1'b0;
         w_ovr_n   = 1'b0;
      end

      case (r_state)
         ST_IDLE: begin
            if (!r_rx_s) begin
               w_state_n = ST_START;
               w_cnt_n   = '0;
            end
         end
         ST_START: begin
            if (r_cnt == c_start_last) begin
               w_cnt_n = '0;
               w_idx_n = 3'd0;
               w_state_n = r_rx_s ? ST_IDLE : ST_DATA;
            end else begin
               w_cnt_n = r_cnt + 1'b1;
            end
         end
         ST_DATA: begin
            if (r_cnt == c_bit_last) begin
               w_cnt_n       = '0;
               w_sh_n[r_idx] = r_rx_s;
               if (r_idx == 3'd7) begin
                  w_state_n = ST_STOP;
               end else begin
                  w_idx_n = r_idx + 3'd1;
               end
            end else begin
               w_cnt_n = r_cnt + 1'b1;
            end
         end
         ST_STOP: begin
            if (r_cnt == c_bit_last) begin
               w_cnt_n = '0;
               if (r_rx_s) begin
                  if (!r_valid || rx_ack) begin
                     w_data_n  = r_sh;
                     w_valid_n = 1'b1;
                  end else begin
                     w_ovr_n = 1'b1;
                  end
                  w_state_n = ST_IDLE;
               end else begin
                  w_ferr_n  = 1'b1;
                  w_state_n = ST_BREAK;
               end
            end else begin
               w_cnt_n = r_cnt + 1'b1;
            end
         end
         ST_BREAK: begin
            // A held-low line must return high before another start is accepted.
            if (r_rx_s) begin
               w_state_n = ST_IDLE;
            end
         end
         default: begin
            w_state_n = ST_IDLE;
         end
      endcase
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_ferr;
   assign overrun   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_unit
// Brief  : Self-checking bench for uart_rx_unit: directed frame table, hand
//          corner sequences and random frames against a line-history model.
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_unit;

   localparam int CPB       = 16;
   localparam int HALF      = CPB / 2;
   localparam int STOP_EDGE = 155;
   localparam int LVMAX     = 16384;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       uart_rx = 1'b1;
   logic       rx_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic [10:0] outs;

   assign outs = {rx_data, rx_valid, frame_err, overrun};

   uart_rx_unit #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .uart_rx   (uart_rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ack    (rx_ack),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int edge_n = 0;
   int ferr_seen = 0;
   logic lv [0:LVMAX-1];

   // Reference model: decodes the recorded line value at each edge index.
   int         m_mode = 0;
   int         m_s = 0;
   int         m_resume = 0;
   logic [7:0] m_data = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_ferr = 1'b0;
   logic       m_ovr = 1'b0;

   typedef struct {
      logic [7:0]  data;
      logic        stop;
      int          ack_a;
      int          ack_b;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl [0:8];

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s edge=%0d got data=%h valid=%b ferr=%b ovr=%b, want data=%h valid=%b ferr=%b ovr=%b",
                  name, edge_n, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic model_edge(input int n);
      int j;
      logic pre_valid;
      logic [7:0] b;
      j = n - 3;
      pre_valid = m_valid;
      m_ferr = 1'b0;
      if (!reset) begin
         m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
         m_mode = 0; m_resume = n + 1;
      end else begin
         if (rx_ack && m_valid) begin
            m_valid = 1'b0; m_ovr = 1'b0;
         end
         if (j >= 0) begin
            if (m_mode == 0) begin
               if (j >= m_resume && lv[j] == 1'b0) begin
                  m_s = j; m_mode = 1;
               end
            end else if (m_mode == 1) begin
               if (j == m_s + HALF && lv[j] == 1'b1) begin
                  m_mode = 0; m_resume = j + 1;
               end else if (j == m_s + HALF + 9 * CPB) begin
                  m_resume = j + 1;
                  if (lv[j] == 1'b1) begin
                     for (int k = 0; k < 8; k++) b[k] = lv[m_s + HALF + (k + 1) * CPB];
                     if (!pre_valid || rx_ack) begin
                        m_data = b; m_valid = 1'b1;
                     end else begin
                        m_ovr = 1'b1;
                     end
                     m_mode = 0;
                  end else begin
                     m_ferr = 1'b1; m_mode = 2;
                  end
               end
            end else begin
               if (j >= m_resume && lv[j] == 1'b1) begin
                  m_mode = 0; m_resume = j + 1;
               end
            end
         end
      end
   endtask

   task automatic step();
      if (edge_n >= LVMAX) begin
         $display("FAIL cycle_budget edge=%0d got over-budget want below %0d", edge_n, LVMAX);
         $fatal(1, "cycle budget exhausted");
      end
      lv[edge_n] = uart_rx;
      @(posedge clk);
      model_edge(edge_n);
      edge_n++;
      #1;
      check("cycle", outs, {m_data, m_valid, m_ferr, m_ovr});
      if (frame_err) ferr_seen++;
   endtask

   task automatic idle(input int n);
      uart_rx = 1'b1;
      repeat (n) step();
   endtask

   task automatic ack_pulse();
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;
   endtask

   // Drives one frame; k is the edge index relative to the first edge after the fall.
   task automatic send(input logic [7:0] b, input logic stop, input int ack_a, input int ack_b,
                       input int rst_at, input logic do_chk, input logic [10:0] exp, input string name);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int k = 0; k < 10 * CPB; k++) begin
         uart_rx = fr[k / CPB];
         rx_ack  = (k == ack_a) || (k == ack_b);
         reset   = !((rst_at >= 0) && (k >= rst_at) && (k < rst_at + 2));
         step();
         if (do_chk && k == STOP_EDGE) check(name, outs, exp);
      end
      rx_ack = 1'b0;
      reset  = 1'b1;
   endtask

   initial begin
      int f0;
      logic [7:0] rb;
      logic rs;
      int aa;

      tbl[0] = '{8'h55, 1'b1, -1,  -1,  {8'h55, 3'b100}};
      tbl[1] = '{8'hA3, 1'b1, 20,  156, {8'hA3, 3'b100}};
      tbl[2] = '{8'h0F, 1'b1, -1,  156, {8'h0F, 3'b100}};
      tbl[3] = '{8'h12, 1'b1, -1,  -1,  {8'h12, 3'b100}};
      tbl[4] = '{8'h34, 1'b1, -1,  -1,  {8'h12, 3'b101}};
      tbl[5] = '{8'h99, 1'b1, 155, -1,  {8'h99, 3'b100}};
      tbl[6] = '{8'h34, 1'b1, 155, -1,  {8'h34, 3'b100}};
      tbl[7] = '{8'h00, 1'b1, 10,  -1,  {8'h00, 3'b100}};
      tbl[8] = '{8'h80, 1'b1, 10,  -1,  {8'h80, 3'b100}};

      reset = 1'b0;
      repeat (4) step();
      check("reset_state", outs, 11'h000);
      reset = 1'b1;
      idle(10);

      for (int i = 0; i < 9; i++)
         send(tbl[i].data, tbl[i].stop, tbl[i].ack_a, tbl[i].ack_b, -1, 1'b1, tbl[i].exp,
              $sformatf("tbl%0d", i));
      idle(5);

      // Bad stop bit followed by a held-low line.
      ack_pulse();
      f0 = ferr_seen;
      send(8'hFF, 1'b0, -1, -1, -1, 1'b1, {8'h80, 3'b010}, "stop0");
      uart_rx = 1'b0;
      repeat (40) step();
      idle(200);
      check("ferr_pulses", 11'(ferr_seen - f0), 11'd1);
      check("break_no_valid", outs, {8'h80, 3'b000});

      // Short glitch must not start a frame.
      idle(20);
      uart_rx = 1'b0;
      repeat (3) step();
      idle(60);
      check("glitch", outs, {8'h80, 3'b000});

      // Reset during bit 4 of a frame after building valid+overrun state.
      send(8'h3C, 1'b1, -1, -1, -1, 1'b0, 11'h000, "pre1");
      send(8'h5A, 1'b1, -1, -1, -1, 1'b1, {8'h3C, 3'b101}, "pre_ovr");
      send(8'hF3, 1'b1, -1, -1, 5 * CPB + 4, 1'b0, 11'h000, "rst");
      check("mid_reset", outs, 11'h000);
      idle(30);
      send(8'hC6, 1'b1, -1, -1, -1, 1'b1, {8'hC6, 3'b100}, "after_reset");
      idle(10);

      // Random frames, acks, gaps, bad stops and glitches.
      for (int i = 0; i < 16; i++) begin
         rb = 8'($urandom);
         rs = ($urandom_range(0, 7) != 0);
         aa = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 10 * CPB - 1));
         send(rb, rs, aa, -1, -1, 1'b0, 11'h000, "rand");
         if (!rs) begin
            uart_rx = 1'b0;
            repeat ($urandom_range(0, 30)) step();
         end
         idle($urandom_range(0, 12));
         if ($urandom_range(0, 5) == 0) begin
            uart_rx = 1'b0;
            repeat ($urandom_range(1, 6)) step();
            idle(4);
         end
      end
      idle(200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
